// File: rtl/gf180mcu_as_sc_mcu7t3v3__cell_bist.sv
`default_nettype none
// ============================================================================
// Module  : gf180mcu_as_sc_mcu7t3v3__cell_bist
// Brief   : Exhaustive-vector driver/checker for one combinational cell, with
//           truth-table compare and 16-bit MISR compaction of the response.
// Revision: 1.0 - initial release
// ============================================================================
module gf180mcu_as_sc_mcu7t3v3__cell_bist #(
    parameter int NIN    = 4,
    parameter int SETTLE = 2
) (
    input  logic                  CLK,
    input  logic                  RN,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic [(2**NIN)-1:0]   TRUTH,
    output logic [NIN-1:0]        STIM,
    input  logic                  RESP,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  PASS,
    output logic [NIN:0]          ERR_CNT,
    output logic [NIN-1:0]        FAIL_IDX,
    output logic [15:0]           SIG
);

    localparam logic [3:0]     c_SETTLE   = 4'(SETTLE);
    localparam logic [NIN-1:0] c_LAST     = NIN'((2**NIN) - 1);
    localparam logic [NIN-1:0] c_STIM_ONE = NIN'(1);
    localparam logic [NIN:0]   c_ERR_ONE  = (NIN+1)'(1);
    localparam logic [15:0]    c_POLY     = 16'h1021;
    localparam logic [15:0]    c_SEED     = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_CAPT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [NIN-1:0] r_stim, w_stim_nxt;
    logic           r_busy, w_busy_nxt;
    logic           r_done, w_done_nxt;
    logic           r_pass, w_pass_nxt;
    logic [NIN:0]   r_err_cnt, w_err_cnt_nxt;
    logic [NIN-1:0] r_fail_idx, w_fail_idx_nxt;
    logic [15:0]    r_sig, w_sig_nxt;
    logic [3:0]     r_cnt, w_cnt_nxt;

    logic           w_mismatch;
    logic [15:0]    w_sig_step;
    // With zero settle time every vector is captured back-to-back in CAPT.
    state_t         w_vec_state;

    assign w_mismatch  = (RESP != TRUTH[r_stim]);
    assign w_sig_step  = {r_sig[14:0], 1'b0} ^ (r_sig[15] ? c_POLY : 16'h0000)
                         ^ {15'b0, RESP};
    assign w_vec_state = (c_SETTLE == 4'd0) ? S_CAPT : S_WAIT;

    always_ff @(posedge CLK) begin
        if (!RN) begin
            r_state    <= S_IDLE;
            r_stim     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err_cnt  <= '0;
            r_fail_idx <= '0;
            r_sig      <= 16'h0000;
            r_cnt      <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_stim     <= w_stim_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_pass     <= w_pass_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
            r_fail_idx <= w_fail_idx_nxt;
            r_sig      <= w_sig_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_stim_nxt     = r_stim;
        w_busy_nxt     = r_busy;
        w_done_nxt     = r_done;
        w_pass_nxt     = r_pass;
        w_err_cnt_nxt  = r_err_cnt;
        w_fail_idx_nxt = r_fail_idx;
        w_sig_nxt      = r_sig;
        w_cnt_nxt      = r_cnt;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (START) begin
                    w_state_nxt    = w_vec_state;
                    w_stim_nxt     = '0;
                    w_busy_nxt     = 1'b1;
                    w_done_nxt     = 1'b0;
                    w_pass_nxt     = 1'b0;
                    w_err_cnt_nxt  = '0;
                    w_fail_idx_nxt = '0;
                    w_sig_nxt      = c_SEED;
                    w_cnt_nxt      = c_SETTLE;
                end else if (r_state == S_DONE) begin
                    // Results are published one cycle after the last capture.
                    w_done_nxt = 1'b1;
                    w_busy_nxt = 1'b0;
                    w_pass_nxt = (r_err_cnt == '0);
                end
            end

            S_WAIT: begin
                if (ABORT) begin
                    w_state_nxt = S_IDLE;
                    w_stim_nxt  = '0;
                    w_busy_nxt  = 1'b0;
                end else if (r_cnt <= 4'd1) begin
                    w_state_nxt = S_CAPT;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end

            S_CAPT: begin
                if (ABORT) begin
                    w_state_nxt = S_IDLE;
                    w_stim_nxt  = '0;
                    w_busy_nxt  = 1'b0;
                end else begin
                    if (w_mismatch) begin
                        w_err_cnt_nxt = r_err_cnt + c_ERR_ONE;
                        if (r_err_cnt == '0)
                            w_fail_idx_nxt = r_stim;
                    end
                    w_sig_nxt = w_sig_step;
                    if (r_stim == c_LAST) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_stim_nxt  = r_stim + c_STIM_ONE;
                        w_cnt_nxt   = c_SETTLE;
                        w_state_nxt = w_vec_state;
                    end
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign STIM     = r_stim;
    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign PASS     = r_pass;
    assign ERR_CNT  = r_err_cnt;
    assign FAIL_IDX = r_fail_idx;
    assign SIG      = r_sig;

endmodule
`default_nettype wire
